// File: rtl/hwpe_stream_streamer_cmd_fifo_pkg.sv
// Shared streamer types plus the command-FIFO FSM state enum and default depth.
package hwpe_stream_package;

  typedef struct packed {
    logic [31:0] base_addr;
    logic [31:0] trans_size;
    logic [15:0] line_stride;
    logic [15:0] line_length;
    logic [15:0] feat_stride;
    logic [15:0] feat_length;
    logic [15:0] feat_roll;
    logic        loop_outer;
    logic        realign_type;
    logic [7:0]  step;
  } ctrl_addressgen_t;

  typedef struct packed {
    logic             req_start;
    ctrl_addressgen_t addressgen_ctrl;
  } ctrl_sourcesink_t;

  typedef struct packed {
    logic ready_start;
    logic done;
    logic ready_fifo;
  } flags_sourcesink_t;

  typedef enum logic [1:0] {
    CMD_FIFO_IDLE,
    CMD_FIFO_ISSUE,
    CMD_FIFO_RUN
  } cmd_fifo_state_t;

  localparam int unsigned HWPE_STREAM_CMD_FIFO_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/hwpe_stream_streamer_cmd_fifo_mem.sv
// Descriptor storage: DEPTH-entry circular buffer with head read-out and count.
module hwpe_stream_streamer_cmd_fifo_mem
  import hwpe_stream_package::*;
#(
  parameter int unsigned DEPTH     = HWPE_STREAM_CMD_FIFO_DEPTH_DEFAULT,
  parameter int unsigned CNT_WIDTH = $clog2(DEPTH+1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  ctrl_sourcesink_t     data_i,
  output ctrl_sourcesink_t     head_o,
  output logic [CNT_WIDTH-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  ctrl_sourcesink_t     mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_WIDTH-1:0] count_q;

  // Slot contents carry no reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer and occupancy update; flush has priority over push/pop.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_WIDTH'(1);
        2'b01:   count_q <= count_q - CNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/hwpe_stream_streamer_cmd_fifo.sv
// Command buffer in front of the streamer: queues descriptors, issues one
// req_start pulse per job, waits for done, and counts completed jobs.
module hwpe_stream_streamer_cmd_fifo
  import hwpe_stream_package::*;
#(
  parameter int unsigned DEPTH         = HWPE_STREAM_CMD_FIFO_DEPTH_DEFAULT,
  parameter int unsigned CNT_WIDTH     = $clog2(DEPTH+1),
  parameter int unsigned JOB_CNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     test_mode_i,
  input  logic                     clear_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  ctrl_sourcesink_t         cmd_i,
  output ctrl_sourcesink_t         streamer_ctrl_o,
  input  flags_sourcesink_t        streamer_flags_i,
  output logic [CNT_WIDTH-1:0]     pending_o,
  output logic                     busy_o,
  output logic                     job_done_o,
  output logic [JOB_CNT_WIDTH-1:0] jobs_done_o
);

  cmd_fifo_state_t          state_q;
  ctrl_sourcesink_t         ctrl_q;
  ctrl_sourcesink_t         head;
  logic                     job_done_q;
  logic [JOB_CNT_WIDTH-1:0] jobs_done_q;
  logic [CNT_WIDTH-1:0]     count;
  logic                     push, pop;

  // Only ready_start and done matter; the rest is kept for interface shape.
  logic unused_inputs;
  assign unused_inputs = ^{test_mode_i, streamer_flags_i.ready_fifo};

  // Ready looks only at occupancy, so a full FIFO refuses even in a pop cycle.
  assign cmd_ready_o = (count != CNT_WIDTH'(DEPTH));
  assign push        = cmd_valid_i && cmd_ready_o;
  assign pop         = (state_q == CMD_FIFO_IDLE) && (count != '0) && streamer_flags_i.ready_start;

  hwpe_stream_streamer_cmd_fifo_mem #(
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) i_mem (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (cmd_i),
    .head_o  (head),
    .count_o (count)
  );

  // Issue FSM with registered descriptor, completion pulse and job counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q     <= CMD_FIFO_IDLE;
      ctrl_q      <= '0;
      job_done_q  <= 1'b0;
      jobs_done_q <= '0;
    end else begin
      job_done_q <= 1'b0;
      case (state_q)
        CMD_FIFO_IDLE: begin
          if (pop) begin
            ctrl_q           <= head;
            ctrl_q.req_start <= 1'b1;
            state_q          <= CMD_FIFO_ISSUE;
          end
        end
        CMD_FIFO_ISSUE: begin
          ctrl_q.req_start <= 1'b0;
          state_q          <= CMD_FIFO_RUN;
        end
        CMD_FIFO_RUN: begin
          if (streamer_flags_i.done) begin
            job_done_q  <= 1'b1;
            jobs_done_q <= jobs_done_q + JOB_CNT_WIDTH'(1);
            state_q     <= CMD_FIFO_IDLE;
          end
        end
        default: state_q <= CMD_FIFO_IDLE;
      endcase
    end
  end

  assign streamer_ctrl_o = ctrl_q;
  assign pending_o       = count;
  assign busy_o          = (state_q != CMD_FIFO_IDLE) || (count != '0);
  assign job_done_o      = job_done_q;
  assign jobs_done_o     = jobs_done_q;

endmodule

// File: tb/tb_hwpe_stream_streamer_cmd_fifo.sv
// Directed bench for the streamer command FIFO.
module tb_hwpe_stream_streamer_cmd_fifo;
  import hwpe_stream_package::*;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              test_mode_i = 1'b0;
  logic              clear_i = 1'b0;
  logic              cmd_valid_i = 1'b0;
  logic              cmd_ready_o;
  ctrl_sourcesink_t  cmd_i = '0;
  ctrl_sourcesink_t  streamer_ctrl_o;
  flags_sourcesink_t streamer_flags_i = '0;
  logic [2:0]        pending_o;
  logic              busy_o;
  logic              job_done_o;
  logic [15:0]       jobs_done_o;

  int errors = 0;
  int total  = 0;

  hwpe_stream_streamer_cmd_fifo dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .test_mode_i      (test_mode_i),
    .clear_i          (clear_i),
    .cmd_valid_i      (cmd_valid_i),
    .cmd_ready_o      (cmd_ready_o),
    .cmd_i            (cmd_i),
    .streamer_ctrl_o  (streamer_ctrl_o),
    .streamer_flags_i (streamer_flags_i),
    .pending_o        (pending_o),
    .busy_o           (busy_o),
    .job_done_o       (job_done_o),
    .jobs_done_o      (jobs_done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ctrl_sourcesink_t mk(input logic [31:0] base, input logic [31:0] size);
    ctrl_sourcesink_t d;
    d = '0;
    d.req_start = 1'b1;  // must be ignored by the FIFO
    d.addressgen_ctrl.base_addr  = base;
    d.addressgen_ctrl.trans_size = size;
    return d;
  endfunction

  initial begin
    // reset
    cyc(); cyc();
    check("rst_req_start", 64'(streamer_ctrl_o.req_start), 64'd0);
    check("rst_ctrl", 64'(streamer_ctrl_o.addressgen_ctrl.base_addr), 64'd0);
    check("rst_ready", 64'(cmd_ready_o), 64'd1);
    check("rst_pending", 64'(pending_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_job_done", 64'(job_done_o), 64'd0);
    check("rst_jobs", 64'(jobs_done_o), 64'd0);
    rst_ni = 1'b1;

    // single job: req_start at push+2 for one cycle, done 10 cycles later
    streamer_flags_i.ready_start = 1'b1;
    cmd_i = mk(32'h1000, 32'd64);
    cmd_valid_i = 1'b1;
    cyc();
    cmd_valid_i = 1'b0;
    check("t1_pend_after_push", 64'(pending_o), 64'd1);
    check("t1_req_t1", 64'(streamer_ctrl_o.req_start), 64'd0);
    cyc();
    check("t1_req_t2", 64'(streamer_ctrl_o.req_start), 64'd1);
    check("t1_base", 64'(streamer_ctrl_o.addressgen_ctrl.base_addr), 64'h1000);
    check("t1_size", 64'(streamer_ctrl_o.addressgen_ctrl.trans_size), 64'd64);
    check("t1_busy", 64'(busy_o), 64'd1);
    cyc();
    check("t1_req_t3", 64'(streamer_ctrl_o.req_start), 64'd0);
    check("t1_base_hold", 64'(streamer_ctrl_o.addressgen_ctrl.base_addr), 64'h1000);
    for (int i = 0; i < 8; i++) cyc();
    check("t1_no_early_done", 64'(job_done_o), 64'd0);
    streamer_flags_i.done = 1'b1;
    cyc();
    streamer_flags_i.done = 1'b0;
    check("t1_job_done", 64'(job_done_o), 64'd1);
    check("t1_jobs", 64'(jobs_done_o), 64'd1);
    check("t1_idle_busy", 64'(busy_o), 64'd0);
    cyc();
    check("t1_pulse_end", 64'(job_done_o), 64'd0);

    // fill to full with ready_start low, fifth push waits
    streamer_flags_i.ready_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_i = mk(32'(i * 32'h100), 32'd16);
      cmd_valid_i = 1'b1;
      cyc();
      check("t2_fill_pending", 64'(pending_o), 64'(i + 1));
    end
    check("t2_full_ready", 64'(cmd_ready_o), 64'd0);
    cmd_i = mk(32'h400, 32'd16);
    cyc();
    check("t2_full_refuse", 64'(pending_o), 64'd4);
    // pop cycle at full: push refused now, accepted next cycle (4,3,4)
    streamer_flags_i.ready_start = 1'b1;
    cyc();
    check("t3_pend_pop", 64'(pending_o), 64'd3);
    check("t3_issue0", 64'(streamer_ctrl_o.req_start), 64'd1);
    check("t3_base0", 64'(streamer_ctrl_o.addressgen_ctrl.base_addr), 64'h0);
    check("t3_ready", 64'(cmd_ready_o), 64'd1);
    cyc();
    cmd_valid_i = 1'b0;
    check("t3_pend_refill", 64'(pending_o), 64'd4);
    check("t3_req_low", 64'(streamer_ctrl_o.req_start), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      streamer_flags_i.done = 1'b1;
      cyc();
      streamer_flags_i.done = 1'b0;
      check("t2_loop_done", 64'(job_done_o), 64'd1);
      cyc();
      check("t2_loop_req", 64'(streamer_ctrl_o.req_start), 64'd1);
      check("t2_loop_base", 64'(streamer_ctrl_o.addressgen_ctrl.base_addr), 64'(k * 32'h100));
      cyc();
    end
    streamer_flags_i.done = 1'b1;
    cyc();
    streamer_flags_i.done = 1'b0;
    check("t2_jobs", 64'(jobs_done_o), 64'd6);
    check("t2_pending", 64'(pending_o), 64'd0);

    // done in IDLE is ignored
    streamer_flags_i.done = 1'b1;
    cyc();
    streamer_flags_i.done = 1'b0;
    check("t4_idle_pulse", 64'(job_done_o), 64'd0);
    check("t4_idle_jobs", 64'(jobs_done_o), 64'd6);
    // done in ISSUE is ignored
    cmd_i = mk(32'h2000, 32'd8);
    cmd_valid_i = 1'b1;
    cyc();
    cmd_valid_i = 1'b0;
    cyc();
    check("t4_in_issue", 64'(streamer_ctrl_o.req_start), 64'd1);
    streamer_flags_i.done = 1'b1;
    cyc();
    streamer_flags_i.done = 1'b0;
    check("t4_issue_pulse", 64'(job_done_o), 64'd0);
    check("t4_issue_jobs", 64'(jobs_done_o), 64'd6);
    check("t4_run_busy", 64'(busy_o), 64'd1);
    cyc();
    check("t4_issue_pulse2", 64'(job_done_o), 64'd0);
    streamer_flags_i.done = 1'b1;
    cyc();
    streamer_flags_i.done = 1'b0;
    check("t4_run_pulse", 64'(job_done_o), 64'd1);
    check("t4_run_jobs", 64'(jobs_done_o), 64'd7);

    // clear in RUN with two pending
    cmd_valid_i = 1'b1;
    cmd_i = mk(32'h3000, 32'd4);
    cyc();
    cmd_i = mk(32'h3100, 32'd4);
    cyc();
    cmd_i = mk(32'h3200, 32'd4);
    cyc();
    cmd_valid_i = 1'b0;
    check("t5_pending2", 64'(pending_o), 64'd2);
    check("t5_busy_pre", 64'(busy_o), 64'd1);
    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
    check("t5_clr_pending", 64'(pending_o), 64'd0);
    check("t5_clr_busy", 64'(busy_o), 64'd0);
    check("t5_clr_req", 64'(streamer_ctrl_o.req_start), 64'd0);
    check("t5_clr_base", 64'(streamer_ctrl_o.addressgen_ctrl.base_addr), 64'd0);
    check("t5_clr_ready", 64'(cmd_ready_o), 64'd1);
    streamer_flags_i.done = 1'b1;
    cyc();
    streamer_flags_i.done = 1'b0;
    check("t5_late_pulse", 64'(job_done_o), 64'd0);
    check("t5_late_jobs", 64'(jobs_done_o), 64'd0);

    // job counter wraps 0xFFFF -> 0x0000
    force dut.jobs_done_q = 16'hFFFF;
    cyc();
    release dut.jobs_done_q;
    cyc();
    check("t6_preload", 64'(jobs_done_o), 64'hFFFF);
    cmd_i = mk(32'h4000, 32'd0);
    cmd_valid_i = 1'b1;
    cyc();
    cmd_valid_i = 1'b0;
    cyc();
    cyc();
    streamer_flags_i.done = 1'b1;
    cyc();
    streamer_flags_i.done = 1'b0;
    check("t6_wrap_pulse", 64'(job_done_o), 64'd1);
    check("t6_wrap_jobs", 64'(jobs_done_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end

endmodule

// File: doc/hwpe_stream_streamer_cmd_fifo.md
Name: hwpe_stream_streamer_cmd_fifo

Overview:
- Controller-side command buffer that sits directly upstream of the streamer queue stage.
- Accepts source/sink job descriptors (ctrl_sourcesink_t) from the controller through a valid/ready handshake and stores up to DEPTH of them in order.
- Issues each descriptor to the streamer as a single-cycle req_start pulse, then waits for the streamer's done before issuing the next, so the controller can post jobs back-to-back without polling.
- Returns per-job completion pulses and counts to the controller.

Parameters:
- DEPTH, 4, number of descriptor slots; power of two, at least 2.
- CNT_WIDTH, $clog2(DEPTH+1), width of the occupancy count.
- JOB_CNT_WIDTH, 16, width of the completed-job counter.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- test_mode_i  in  1  unused functionally; kept for interface uniformity.
- clear_i  in  1  synchronous flush, same effect as reset.
- cmd_valid_i  in  1  controller offers a descriptor.
- cmd_ready_o  out  1  FIFO can accept; equals !full.
- cmd_i  in  ctrl_sourcesink_t  descriptor; cmd_i.req_start is ignored.
- streamer_ctrl_o  out  ctrl_sourcesink_t  registered descriptor to the streamer queue.
- streamer_flags_i  in  flags_sourcesink_t  streamer status; only ready_start and done are used.
- pending_o  out  CNT_WIDTH  descriptors stored and not yet issued.
- busy_o  out  1  high when a job is issued and not yet done, or pending_o != 0.
- job_done_o  out  1  one-cycle pulse per completed job.
- jobs_done_o  out  JOB_CNT_WIDTH  completed-job count; wraps modulo 2^JOB_CNT_WIDTH.

Behaviour:
- Reset and clear: synchronous, active-low on rst_ni; clear_i has identical effect.
  - Outputs after reset/clear: streamer_ctrl_o = '0 (req_start = 0), cmd_ready_o = 1, pending_o = 0, busy_o = 0, job_done_o = 0, jobs_done_o = 0.
  - FSM returns to IDLE. FIFO pointers are zeroed; stored contents are don't-care.
- Push: a descriptor is written when cmd_valid_i && cmd_ready_o.
  - cmd_ready_o = (pending_o != DEPTH) and does not depend on a same-cycle pop. A full FIFO therefore refuses the push even in a pop cycle.
  - Simultaneous push and pop leaves pending_o unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, RUN.
  - IDLE -> ISSUE when pending_o != 0 and streamer_flags_i.ready_start == 1. On that edge the head is popped and its descriptor is registered into streamer_ctrl_o with req_start = 1.
  - ISSUE lasts exactly one cycle, so req_start is high for exactly one cycle. ISSUE -> RUN unconditionally; on that edge req_start returns to 0 while the other streamer_ctrl_o fields hold the issued descriptor.
  - RUN -> IDLE when streamer_flags_i.done == 1. ready_start is ignored in RUN.
  - On the RUN -> IDLE edge: job_done_o is 1 for the next cycle and jobs_done_o increments.
- Timing:
  - Latency from a push handshake at cycle t on an empty FIFO, with ready_start high, to req_start high is 2 cycles (t+2).
  - Minimum gap between consecutive req_start pulses is done cycle + 2.
- A done seen in IDLE or ISSUE is ignored: it does not count and produces no pulse.
- clear_i mid-RUN: the job is abandoned, no job_done_o is produced, and a later done from the streamer is ignored.
- clear_i has priority over push, pop and done in the same cycle.
- busy_o is combinational from state and pending_o.

Decomposition:
- hwpe_stream_package supplies ctrl_sourcesink_t and flags_sourcesink_t, unchanged.
- Add to hwpe_stream_package:
  - an enum type for the FSM states IDLE, ISSUE, RUN;
  - constant HWPE_STREAM_CMD_FIFO_DEPTH_DEFAULT = 4.
- One sub-module: hwpe_stream_streamer_cmd_fifo_mem, a DEPTH x ctrl_sourcesink_t register array with read/write pointers and count, no FSM. The parent holds the FSM, the output register and the job counter.

Test Plan:
- Reset, then push one descriptor (base_addr = 0x1000, trans_size = 64) with ready_start = 1 -> req_start high for exactly one cycle at push+2 with base_addr 0x1000 and trans_size 64. Assert done 10 cycles later -> job_done_o pulses once and jobs_done_o = 1.
- Push 5 descriptors into the DEPTH = 4 FIFO while ready_start = 0 -> cmd_ready_o drops after the 4th push and pending_o = 4. Raise ready_start and cycle done -> the 5th push is accepted once space frees, and issue order is preserved with base_addr 0x0, 0x100, 0x200, 0x300, 0x400.
- At full, hold cmd_valid_i high during a pop cycle -> push is refused that cycle and accepted the cycle after; pending_o goes 4, 3, 4.
- Pulse done while in IDLE, and also in the ISSUE cycle -> no job_done_o and jobs_done_o unchanged.
- Assert clear_i in RUN with 2 descriptors pending -> next cycle pending_o = 0, busy_o = 0, req_start = 0. A subsequent done produces no pulse and jobs_done_o = 0.
- Preload jobs_done_o to 0xFFFF (run 65535 zero-length jobs, or force the counter), then complete one more job -> jobs_done_o = 0x0000 and job_done_o pulses.
